// File: rtl/ln_stream_adapter.sv
// Bridges a LANES-wide INT8 stream to a parallel layer-norm engine: collects
// one N-element vector, kicks the engine, then streams the result back out.
module ln_stream_adapter #(
  parameter int N     = 176,
  parameter int LANES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [8*LANES-1:0]   s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [8*LANES-1:0]   m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_last,
  output logic signed [7:0]    ln_x [N],
  output logic                 ln_start,
  input  logic signed [7:0]    ln_y [N],
  input  logic                 ln_out_valid,
  output logic                 busy
);

  // state | meaning
  // LOAD  | accepting input beats into ln_x
  // KICK  | one-cycle ln_start pulse; ln_out_valid ignored
  // WAIT  | waiting for the engine's fresh ln_out_valid
  // DRAIN | streaming ln_y out, one beat per m_ready handshake
  typedef enum logic [1:0] {ST_LOAD, ST_KICK, ST_WAIT, ST_DRAIN} state_t;

  localparam int BEATS = N / LANES;
  localparam int BW    = $clog2(BEATS + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  state_t        state, state_nxt;
  logic [BW-1:0] beat, beat_nxt;
  logic          live;
  logic          s_fire, m_fire;

  // live keeps s_ready low until the first edge after reset release
  assign s_ready  = live && (state == ST_LOAD);
  assign s_fire   = s_valid && s_ready;
  assign m_valid  = (state == ST_DRAIN);
  assign m_fire   = m_valid && m_ready;
  assign m_last   = m_valid && (beat == LAST_BEAT);
  assign ln_start = (state == ST_KICK);
  assign busy     = (state != ST_LOAD) || (beat != '0);

  always_comb begin
    state_nxt = state;
    beat_nxt  = beat;
    case (state)
      ST_LOAD: begin
        if (s_fire) begin
          if (beat == LAST_BEAT) begin
            state_nxt = ST_KICK;
            beat_nxt  = '0;
          end else begin
            beat_nxt = beat + BW'(1);
          end
        end
      end
      ST_KICK: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (ln_out_valid) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (m_fire) begin
          if (beat == LAST_BEAT) begin
            state_nxt = ST_LOAD;
            beat_nxt  = '0;
          end else begin
            beat_nxt = beat + BW'(1);
          end
        end
      end
      default: begin
        state_nxt = ST_LOAD;
        beat_nxt  = '0;
      end
    endcase
  end

  always_comb begin
    m_data = '0;
    if (m_valid) begin
      for (int j = 0; j < BEATS; j++) begin
        if (beat == BW'(j)) begin
          for (int k = 0; k < LANES; k++) begin
            m_data[8*k +: 8] = ln_y[j*LANES + k];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_LOAD;
      beat  <= '0;
      live  <= 1'b0;
      for (int i = 0; i < N; i++) ln_x[i] <= '0;
    end else begin
      state <= state_nxt;
      beat  <= beat_nxt;
      live  <= 1'b1;
      if (s_fire) begin
        for (int j = 0; j < BEATS; j++) begin
          if (beat == BW'(j)) begin
            for (int k = 0; k < LANES; k++) begin
              ln_x[j*LANES + k] <= s_data[8*k +: 8];
            end
          end
        end
      end
    end
  end

endmodule
